// File: rtl/async_fifo_pkg.sv
// Shared constants and the pointer-width helper for the single-clock FIFO.
// Optional error flags are enabled with the ASYNC_FIFO_ERR_EN macro.
package async_fifo_pkg;

   localparam int FIFO_DEPTH_DEF = 16;
   localparam int FIFO_WIDTH_DEF = 8;

   // Address width of the storage array; pointers carry one extra wrap bit.
   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/async_fifo_if.sv
// Producer/consumer handshake bundle for async_fifo.
// Defining ASYNC_FIFO_ERR_EN adds the sticky overflow/underflow flags.
interface async_fifo_if
   import async_fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF
);

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             empty;
   logic             full;
`ifdef ASYNC_FIFO_ERR_EN
   logic             overflow;
   logic             underflow;
`endif

`ifdef ASYNC_FIFO_ERR_EN
   modport master (
      output wr_en, rd_en, data_in,
      input  data_out, empty, full, overflow, underflow
   );

   modport slave (
      input  wr_en, rd_en, data_in,
      output data_out, empty, full, overflow, underflow
   );
`else
   modport master (
      output wr_en, rd_en, data_in,
      input  data_out, empty, full
   );

   modport slave (
      input  wr_en, rd_en, data_in,
      output data_out, empty, full
   );
`endif

endinterface

// File: rtl/async_fifo_mem.sv
// DEPTH x WIDTH storage with a synchronous write port and a registered read
// port whose output holds its value on cycles without an accepted read.
module async_fifo_mem
   import async_fifo_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH_DEF,
   parameter int WIDTH  = FIFO_WIDTH_DEF,
   parameter int ADDR_W = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO top: wrap-bit pointers, full/empty flags and storage.
// Defining ASYNC_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = FIFO_WIDTH_DEF
) (
   input logic          clk,
   input logic          rst,
   async_fifo_if.slave  bus
);

   localparam int ADDR_W = addr_width(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W:0]  wr_ptr;
   logic [ADDR_W:0]  rd_ptr;
   logic             empty_flag;
   logic             full_flag;
   logic             rd_accept;
   logic             wr_accept;
   logic [WIDTH-1:0] rd_data;

   assign empty_flag = (wr_ptr == rd_ptr);
   assign full_flag  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                       (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

   // A read frees a slot in the same cycle, so a write at full may still go in.
   assign rd_accept = bus.rd_en && !empty_flag;
   assign wr_accept = bus.wr_en && (!full_flag || rd_accept);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   async_fifo_mem #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (bus.data_in),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   assign bus.data_out = rd_data;
   assign bus.empty    = empty_flag;
   assign bus.full     = full_flag;

`ifdef ASYNC_FIFO_ERR_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr_en && full_flag && !rd_accept) begin
            overflow_q <= 1'b1;
         end
         if (bus.rd_en && empty_flag) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_async_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   async_fifo_if #(.WIDTH(WIDTH)) bus ();

   async_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] model_q[$];
   logic [7:0] model_dout = 8'h00;
   bit         model_ovf  = 1'b0;
   bit         model_unf  = 1'b0;

   typedef struct {
      bit         rst;
      bit         wr;
      bit         rd;
      logic [7:0] din;
      logic [7:0] exp_dout;
      bit         exp_empty;
      bit         exp_full;
   } vector_t;

   vector_t vectors[9];

   logic [7:0] fill_data [16] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d, 8'h8d, 8'h65, 8'h12,
                                  8'h01, 8'h0e, 8'h76, 8'h3d, 8'hed, 8'h8c, 8'hf9, 8'hc6};

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // The model works purely on occupancy: a queue of bytes in write order.
   task automatic model_step(input bit r, input bit w, input bit rd, input logic [7:0] d);
      bit rd_ok;
      bit wr_ok;
      if (r) begin
         model_q.delete();
         model_dout = 8'h00;
         model_ovf  = 1'b0;
         model_unf  = 1'b0;
      end else begin
         rd_ok = rd && (model_q.size() > 0);
         wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
         if (w && (model_q.size() == DEPTH) && !rd_ok) model_ovf = 1'b1;
         if (rd && (model_q.size() == 0)) model_unf = 1'b1;
         if (rd_ok) model_dout = model_q.pop_front();
         if (wr_ok) model_q.push_back(d);
      end
   endtask

   task automatic check_output(input string tag);
      check_val({tag, ".data_out"}, 32'(bus.data_out), 32'(model_dout));
      check_val({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
      check_val({tag, ".full"}, 32'(bus.full), 32'(model_q.size() == DEPTH));
`ifdef ASYNC_FIFO_ERR_EN
      check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(model_ovf));
      check_val({tag, ".underflow"}, 32'(bus.underflow), 32'(model_unf));
`endif
   endtask

   task automatic apply_stimulus(input bit r, input bit w, input bit rd, input logic [7:0] d,
                                 input string tag);
      @(negedge clk);
      rst         = r;
      bus.wr_en   = w;
      bus.rd_en   = rd;
      bus.data_in = d;
      @(posedge clk);
      model_step(r, w, rd, d);
      #1;
      check_output(tag);
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = 8'h00;

      // rst wr rd din dout empty full
      vectors[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      vectors[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
      vectors[2] = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0};
      vectors[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0};
      vectors[4] = '{1'b0, 1'b1, 1'b0, 8'h24, 8'h11, 1'b0, 1'b0};
      vectors[5] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h11, 1'b0, 1'b0};
      vectors[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h24, 1'b0, 1'b0};
      vectors[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h81, 1'b1, 1'b0};
      vectors[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h81, 1'b1, 1'b0};

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vectors[i].rst, vectors[i].wr, vectors[i].rd, vectors[i].din,
                        $sformatf("vec%0d", i));
         check_val($sformatf("vec%0d.tbl_dout", i), 32'(bus.data_out), 32'(vectors[i].exp_dout));
         check_val($sformatf("vec%0d.tbl_empty", i), 32'(bus.empty), 32'(vectors[i].exp_empty));
         check_val($sformatf("vec%0d.tbl_full", i), 32'(bus.full), 32'(vectors[i].exp_full));
      end

      // Fill to the full boundary, then push one extra write that must be dropped.
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, "rst_fill");
      for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 1'b0, fill_data[i], "fill_wr");
      check_val("full_after_16", 32'(bus.full), 32'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'hAA, "wr17");
      check_val("full_after_17", 32'(bus.full), 32'd1);
`ifdef ASYNC_FIFO_ERR_EN
      check_val("overflow_set", 32'(bus.overflow), 32'd1);
`endif

      // Read and write together at full: oldest out, 8'h55 queued last.
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'h55, "both_full");
      check_val("both_full.dout", 32'(bus.data_out), 32'h24);
      check_val("both_full.full", 32'(bus.full), 32'd1);
      for (int i = 1; i < 16; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "drain");
         check_val($sformatf("drain%0d", i), 32'(bus.data_out), 32'(fill_data[i]));
      end
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "drain_last");
      check_val("drain_last.dout", 32'(bus.data_out), 32'h55);
      check_val("drain_last.empty", 32'(bus.empty), 32'd1);

      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "empty_rd");
      check_val("empty_rd.dout", 32'(bus.data_out), 32'h55);
`ifdef ASYNC_FIFO_ERR_EN
      check_val("underflow_set", 32'(bus.underflow), 32'd1);
`endif

      // Pointer wrap: 10 in/out, then 12 in/out crosses the array end.
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, "rst_wrap");
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), "wrap_wr10");
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "wrap_rd10");
      for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i), "wrap_wr12");
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "wrap_rd12");
         check_val($sformatf("wrap_order%0d", i), 32'(bus.data_out), 32'(8'hA0 + i));
      end

      // Reset with 5 entries held, then confirm fresh data flows.
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), "mid_wr");
      apply_stimulus(1'b1, 1'b1, 1'b1, 8'hEE, "mid_rst");
      check_val("mid_rst.empty", 32'(bus.empty), 32'd1);
      check_val("mid_rst.dout", 32'(bus.data_out), 32'h00);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h77, "post_wr");
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "post_rd");
      check_val("post_rd.dout", 32'(bus.data_out), 32'h77);

      // Randomized traffic, biased toward writes then reads to visit both flags.
      for (int i = 0; i < 600; i++) begin
         bit r;
         bit w;
         bit rd;
         r  = ($urandom_range(0, 99) == 0);
         w  = (i % 200 < 100) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         rd = (i % 200 < 100) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
         apply_stimulus(r, w, rd, 8'($urandom), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
